// File: rtl/udp_arb_pkg.sv
// Shared types and constants for the UDP TX frame arbiter.
package udp_arb_pkg;

  localparam int SRC_IP_LSB   = 96;
  localparam int DST_IP_LSB   = 64;
  localparam int SRC_PORT_LSB = 48;
  localparam int DST_PORT_LSB = 32;
  localparam int LEN_LSB      = 16;
  localparam int CSUM_LSB     = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HDR     = 2'd1,
    PAYLOAD = 2'd2
  } arb_state_e;

  // Round-robin successor of a port index, wrapping at count-1.
  function automatic int rr_next(input int idx, input int count);
    return (idx >= count - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first set req bit at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             valid
);

  logic [IDX_W-1:0] sel_s;

  // Walk offsets from farthest to nearest so the nearest requester is written last.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    sel_s = '0;
    for (int i = N - 1; i >= 0; i--) begin
      sel_s = IDX_W'((int'(ptr) + i) % N);
      grant = req[sel_s] ? sel_s : grant;
      valid = valid | req[sel_s];
    end
  end

endmodule

// File: rtl/udp_tx_arb_64.sv
// Frame-level round-robin arbiter in front of the 64-bit UDP TX frame input.
// Optional per-port frame/error counters when UDP_TX_ARB_STATS_EN is defined.
module udp_tx_arb_64
  import udp_arb_pkg::*;
#(
  parameter int S_COUNT = 4,
  parameter int HDR_W   = 128,
  parameter int IDX_W   = $clog2(S_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [S_COUNT-1:0]     s_udp_hdr_valid,
  output logic [S_COUNT-1:0]     s_udp_hdr_ready,
  input  logic [S_COUNT*HDR_W-1:0] s_udp_hdr,
  input  logic [S_COUNT*64-1:0]  s_udp_payload_axis_tdata,
  input  logic [S_COUNT*8-1:0]   s_udp_payload_axis_tkeep,
  input  logic [S_COUNT-1:0]     s_udp_payload_axis_tvalid,
  output logic [S_COUNT-1:0]     s_udp_payload_axis_tready,
  input  logic [S_COUNT-1:0]     s_udp_payload_axis_tlast,
  input  logic [S_COUNT-1:0]     s_udp_payload_axis_tuser,
  output logic                   m_udp_hdr_valid,
  input  logic                   m_udp_hdr_ready,
  output logic [HDR_W-1:0]       m_udp_hdr,
  output logic [63:0]            m_udp_payload_axis_tdata,
  output logic [7:0]             m_udp_payload_axis_tkeep,
  output logic                   m_udp_payload_axis_tvalid,
  input  logic                   m_udp_payload_axis_tready,
  output logic                   m_udp_payload_axis_tlast,
  output logic                   m_udp_payload_axis_tuser,
  output logic [IDX_W-1:0]       grant_index,
  output logic                   busy
`ifdef UDP_TX_ARB_STATS_EN
  ,
  output logic [S_COUNT*16-1:0]  frame_count,
  output logic [S_COUNT*16-1:0]  err_count
`endif
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             hdr_valid_q, hdr_valid_d;
  logic [HDR_W-1:0] hdr_q, hdr_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] arb_grant_s;
  logic             arb_valid_s;
  logic             payload_en_s;
  logic             last_done_s;

  rr_arbiter #(.N(S_COUNT), .IDX_W(IDX_W)) u_rr_arbiter (
    .req   (s_udp_hdr_valid),
    .ptr   (rr_ptr_q),
    .grant (arb_grant_s),
    .valid (arb_valid_s)
  );

  assign payload_en_s = (state_q == PAYLOAD);
  assign last_done_s  = payload_en_s && s_udp_payload_axis_tvalid[grant_q] &&
                        m_udp_payload_axis_tready && s_udp_payload_axis_tlast[grant_q];

  // Next-state logic; the header register drains independently of the FSM state.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    hdr_valid_d = hdr_valid_q && !m_udp_hdr_ready;
    hdr_d       = hdr_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (arb_valid_s) begin
          grant_d = arb_grant_s;
          state_d = HDR;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      HDR: begin
        // A requester withdrawing its header releases the grant without a frame.
        if (!s_udp_hdr_valid[grant_q]) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (!hdr_valid_q) begin
          hdr_d       = s_udp_hdr[grant_q*HDR_W +: HDR_W];
          hdr_valid_d = 1'b1;
          state_d     = PAYLOAD;
        end else begin
          state_d = HDR;
        end
      end
      PAYLOAD: begin
        if (last_done_s) begin
          rr_ptr_d = IDX_W'(rr_next(int'(grant_q), S_COUNT));
          state_d  = IDLE;
          busy_d   = 1'b0;
        end else begin
          state_d = PAYLOAD;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      hdr_valid_q <= 1'b0;
      hdr_q       <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      hdr_valid_q <= hdr_valid_d;
      hdr_q       <= hdr_d;
      busy_q      <= busy_d;
    end
  end

  // Ready steering and payload mux; only the granted port is ever connected.
  always_comb begin
    s_udp_hdr_ready           = '0;
    s_udp_payload_axis_tready = '0;
    m_udp_payload_axis_tdata  = 64'd0;
    m_udp_payload_axis_tkeep  = 8'd0;
    m_udp_payload_axis_tvalid = 1'b0;
    m_udp_payload_axis_tlast  = 1'b0;
    m_udp_payload_axis_tuser  = 1'b0;
    if ((state_q == HDR) && !hdr_valid_q) begin
      s_udp_hdr_ready[grant_q] = 1'b1;
    end else begin
      s_udp_hdr_ready = '0;
    end
    if (payload_en_s) begin
      m_udp_payload_axis_tdata             = s_udp_payload_axis_tdata[grant_q*64 +: 64];
      m_udp_payload_axis_tkeep             = s_udp_payload_axis_tkeep[grant_q*8 +: 8];
      m_udp_payload_axis_tvalid            = s_udp_payload_axis_tvalid[grant_q];
      m_udp_payload_axis_tlast             = s_udp_payload_axis_tlast[grant_q];
      m_udp_payload_axis_tuser             = s_udp_payload_axis_tuser[grant_q];
      s_udp_payload_axis_tready[grant_q]   = m_udp_payload_axis_tready;
    end else begin
      s_udp_payload_axis_tready = '0;
    end
  end

  assign m_udp_hdr_valid = hdr_valid_q;
  assign m_udp_hdr       = hdr_q;
  assign grant_index     = grant_q;
  assign busy            = busy_q;

`ifdef UDP_TX_ARB_STATS_EN
  logic [15:0] frame_cnt_q [S_COUNT];
  logic [15:0] frame_cnt_d [S_COUNT];
  logic [15:0] err_cnt_q   [S_COUNT];
  logic [15:0] err_cnt_d   [S_COUNT];

  // Count completed frames per port; errors are frames ending with tuser set.
  always_comb begin
    for (int i = 0; i < S_COUNT; i++) begin
      if (last_done_s && (grant_q == IDX_W'(i))) begin
        frame_cnt_d[i] = frame_cnt_q[i] + 16'd1;
        err_cnt_d[i]   = s_udp_payload_axis_tuser[grant_q] ? err_cnt_q[i] + 16'd1 : err_cnt_q[i];
      end else begin
        frame_cnt_d[i] = frame_cnt_q[i];
        err_cnt_d[i]   = err_cnt_q[i];
      end
      frame_count[i*16 +: 16] = frame_cnt_q[i];
      err_count[i*16 +: 16]   = err_cnt_q[i];
    end
  end

  // Counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < S_COUNT; i++) begin
        frame_cnt_q[i] <= 16'd0;
        err_cnt_q[i]   <= 16'd0;
      end
    end else begin
      for (int i = 0; i < S_COUNT; i++) begin
        frame_cnt_q[i] <= frame_cnt_d[i];
        err_cnt_q[i]   <= err_cnt_d[i];
      end
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_arb_64.sv
// Self-checking bench for udp_tx_arb_64: arbitration table, directed corner cases,
// and randomized frame traffic scored against a frame-level round-robin model.
module tb_udp_tx_arb_64;
  import udp_arb_pkg::*;

  localparam int S  = 4;
  localparam int HW = 128;
  localparam int IW = 2;

  logic              clk;
  logic              rst;
  logic [S-1:0]      s_udp_hdr_valid;
  logic [S-1:0]      s_udp_hdr_ready;
  logic [S*HW-1:0]   s_udp_hdr;
  logic [S*64-1:0]   s_tdata;
  logic [S*8-1:0]    s_tkeep;
  logic [S-1:0]      s_tvalid;
  logic [S-1:0]      s_tready;
  logic [S-1:0]      s_tlast;
  logic [S-1:0]      s_tuser;
  logic              m_udp_hdr_valid;
  logic              m_udp_hdr_ready;
  logic [HW-1:0]     m_udp_hdr;
  logic [63:0]       m_tdata;
  logic [7:0]        m_tkeep;
  logic              m_tvalid;
  logic              m_tready;
  logic              m_tlast;
  logic              m_tuser;
  logic [IW-1:0]     grant_index;
  logic              busy;
`ifdef UDP_TX_ARB_STATS_EN
  logic [S*16-1:0]   frame_count;
  logic [S*16-1:0]   err_count;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  udp_tx_arb_64 #(.S_COUNT(S), .HDR_W(HW)) dut (
    .clk                       (clk),
    .rst                       (rst),
    .s_udp_hdr_valid           (s_udp_hdr_valid),
    .s_udp_hdr_ready           (s_udp_hdr_ready),
    .s_udp_hdr                 (s_udp_hdr),
    .s_udp_payload_axis_tdata  (s_tdata),
    .s_udp_payload_axis_tkeep  (s_tkeep),
    .s_udp_payload_axis_tvalid (s_tvalid),
    .s_udp_payload_axis_tready (s_tready),
    .s_udp_payload_axis_tlast  (s_tlast),
    .s_udp_payload_axis_tuser  (s_tuser),
    .m_udp_hdr_valid           (m_udp_hdr_valid),
    .m_udp_hdr_ready           (m_udp_hdr_ready),
    .m_udp_hdr                 (m_udp_hdr),
    .m_udp_payload_axis_tdata  (m_tdata),
    .m_udp_payload_axis_tkeep  (m_tkeep),
    .m_udp_payload_axis_tvalid (m_tvalid),
    .m_udp_payload_axis_tready (m_tready),
    .m_udp_payload_axis_tlast  (m_tlast),
    .m_udp_payload_axis_tuser  (m_tuser),
    .grant_index               (grant_index),
    .busy                      (busy)
`ifdef UDP_TX_ARB_STATS_EN
    ,
    .frame_count               (frame_count),
    .err_count                 (err_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [127:0] hdr;
    int          nbeats;
    logic [63:0] base;
    logic [7:0]  lkeep;
    logic        user;
  } frame_t;

  frame_t frames[$];
  int     src_q[S][$];
  int     src_pay_q[S][$];
  int     pay_beat[S];
  logic   pay_gate[S];
  int     exp_hdr_q[$];
  int     exp_pay_q[$];
  int     exp_beat;
  int     obs_q[$];
  int     model_ptr;
  int     cyc = 0;
  int     tready_mode, hdr_mode, hdr_hold, src_rand;
  int     beats_seen, pay_while_hdr;
  int     viol_ready, viol_stable, viol_lat, viol_dead, viol_busy;
  logic   hdr_pend_prev, lat_pend, dead_pend;
  logic [127:0] hdr_prev_val;

  task automatic add_frame(input int p, input logic [127:0] h, input int nb,
                           input logic [63:0] base, input logic [7:0] lk, input logic u);
    frame_t f;
    f.port = p; f.hdr = h; f.nbeats = nb; f.base = base; f.lkeep = lk; f.user = u;
    frames.push_back(f);
    src_q[p].push_back(frames.size() - 1);
  endtask

  task automatic flush();
    for (int p = 0; p < S; p++) begin
      src_q[p].delete();
      src_pay_q[p].delete();
      pay_beat[p] = 0;
      pay_gate[p] = 1'b1;
    end
    exp_hdr_q.delete(); exp_pay_q.delete(); obs_q.delete();
    exp_beat = 0; model_ptr = 0;
    tready_mode = 0; hdr_mode = 0; hdr_hold = 0; src_rand = 0;
    hdr_pend_prev = 1'b0; lat_pend = 1'b0; dead_pend = 1'b0;
    viol_ready = 0; viol_stable = 0; viol_lat = 0; viol_dead = 0; viol_busy = 0;
  endtask

  task automatic drive();
    frame_t f;
    int b;
    for (int p = 0; p < S; p++) begin
      if (src_q[p].size() > 0) begin
        s_udp_hdr_valid[p]     = 1'b1;
        s_udp_hdr[p*HW +: HW]  = frames[src_q[p][0]].hdr;
      end else begin
        s_udp_hdr_valid[p]     = 1'b0;
        s_udp_hdr[p*HW +: HW]  = '0;
      end
      if (src_pay_q[p].size() > 0 && pay_gate[p]) begin
        f = frames[src_pay_q[p][0]];
        b = pay_beat[p];
        s_tvalid[p]        = 1'b1;
        s_tdata[p*64 +: 64] = f.base + 64'(b);
        s_tlast[p]         = (b == f.nbeats - 1);
        s_tkeep[p*8 +: 8]  = (b == f.nbeats - 1) ? f.lkeep : 8'hFF;
        s_tuser[p]         = (b == f.nbeats - 1) ? f.user : 1'b0;
      end else begin
        s_tvalid[p] = 1'b0; s_tdata[p*64 +: 64] = 64'd0; s_tlast[p] = 1'b0;
        s_tkeep[p*8 +: 8] = 8'd0; s_tuser[p] = 1'b0;
      end
    end
    case (tready_mode)
      0:       m_tready = 1'b1;
      1:       m_tready = (cyc % 2 == 0);
      default: m_tready = ($urandom_range(0, 2) != 0);
    endcase
    if (cyc < hdr_hold)   m_udp_hdr_ready = 1'b0;
    else if (hdr_mode == 0) m_udp_hdr_ready = 1'b1;
    else                  m_udp_hdr_ready = ($urandom_range(0, 2) != 0);
  endtask

  task automatic monitor();
    logic [S-1:0] one_s, gmask;
    frame_t f;
    int id;
    logic [127:0] exp_beat_v, act_beat_v;
    one_s = 1;
    gmask = one_s << grant_index;
    if (((s_udp_hdr_ready | s_tready) & ~gmask) != '0) viol_ready++;
    if (hdr_pend_prev && (!m_udp_hdr_valid || m_udp_hdr !== hdr_prev_val)) viol_stable++;
    if (lat_pend && !m_udp_hdr_valid) viol_lat++;
    if (dead_pend && (busy || m_tvalid)) viol_dead++;
    hdr_pend_prev = m_udp_hdr_valid && !m_udp_hdr_ready;
    hdr_prev_val  = m_udp_hdr;
    lat_pend      = |(s_udp_hdr_valid & s_udp_hdr_ready);
    dead_pend     = 1'b0;
    if (m_udp_hdr_valid && m_udp_hdr_ready) begin
      if (exp_hdr_q.size() > 0) begin
        id = exp_hdr_q.pop_front();
        check("hdr", m_udp_hdr, frames[id].hdr);
      end else begin
        check("hdr_unexpected", {127'd0, m_udp_hdr_valid}, 128'd0);
      end
    end
    if (m_tvalid && m_tready) begin
      beats_seen++;
      if (m_udp_hdr_valid) pay_while_hdr++;
      if (!busy) viol_busy++;
      if (exp_pay_q.size() > 0) begin
        f = frames[exp_pay_q[0]];
        exp_beat_v = {52'd0, 2'(f.port), f.base + 64'(exp_beat),
                      (exp_beat == f.nbeats - 1) ? f.lkeep : 8'hFF,
                      (exp_beat == f.nbeats - 1),
                      (exp_beat == f.nbeats - 1) ? f.user : 1'b0};
        act_beat_v = {52'd0, grant_index, m_tdata, m_tkeep, m_tlast, m_tuser};
        check("beat", act_beat_v, exp_beat_v);
        if (exp_beat == f.nbeats - 1) begin
          void'(exp_pay_q.pop_front());
          exp_beat = 0;
        end else begin
          exp_beat++;
        end
      end else begin
        check("beat_unexpected", {127'd0, m_tvalid}, 128'd0);
      end
      if (m_tlast) begin
        obs_q.push_back(int'(grant_index));
        dead_pend = 1'b1;
      end
    end
  endtask

  task automatic update(input logic [S-1:0] hs_hdr, input logic [S-1:0] hs_pay);
    for (int p = 0; p < S; p++) begin
      if (hs_hdr[p]) src_pay_q[p].push_back(src_q[p].pop_front());
      if (hs_pay[p]) begin
        if (pay_beat[p] == frames[src_pay_q[p][0]].nbeats - 1) begin
          void'(src_pay_q[p].pop_front());
          pay_beat[p] = 0;
        end else begin
          pay_beat[p]++;
        end
      end
      if (!(s_tvalid[p] && !hs_pay[p]))
        pay_gate[p] = (src_rand != 0) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  // One clock: drive at posedge+1, observe at the falling edge, advance sources after posedge.
  task automatic tick();
    logic [S-1:0] hs_hdr, hs_pay;
    drive();
    #4;
    hs_hdr = s_udp_hdr_valid & s_udp_hdr_ready;
    hs_pay = s_tvalid & s_tready;
    monitor();
    @(posedge clk); #1;
    update(hs_hdr, hs_pay);
    cyc++;
  endtask

  // Reference: all queued frames present at once, served one frame per grant in RR order.
  task automatic run_batch(input int budget);
    int tmp[S][$];
    int total, n, p;
    bit found;
    total = 0;
    for (int q = 0; q < S; q++) begin
      tmp[q].delete();
      foreach (src_q[q][k]) tmp[q].push_back(src_q[q][k]);
      total += src_q[q].size();
    end
    while (total > 0) begin
      found = 0;
      for (int off = 0; off < S; off++) begin
        p = (model_ptr + off) % S;
        if (!found && tmp[p].size() > 0) begin
          exp_hdr_q.push_back(tmp[p][0]);
          exp_pay_q.push_back(tmp[p].pop_front());
          model_ptr = (p + 1) % S;
          found = 1;
          total--;
        end
      end
    end
    obs_q.delete(); beats_seen = 0; pay_while_hdr = 0;
    n = 0;
    while ((exp_hdr_q.size() > 0 || exp_pay_q.size() > 0) && n < budget) begin
      tick();
      n++;
    end
    check("batch_done", 128'(exp_hdr_q.size() + exp_pay_q.size()), 128'd0);
    exp_hdr_q.delete(); exp_pay_q.delete();
    tick(); tick();
    check("ready_isolation", 128'(viol_ready), 128'd0);
    check("hdr_stable", 128'(viol_stable), 128'd0);
    check("hdr_latency", 128'(viol_lat), 128'd0);
    check("dead_cycle", 128'(viol_dead), 128'd0);
    check("busy_in_frame", 128'(viol_busy), 128'd0);
    viol_ready = 0; viol_stable = 0; viol_lat = 0; viol_dead = 0; viol_busy = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    flush();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic [S-1:0]  req;
    logic [IW-1:0] grant;
    logic          busy;
    logic [S-1:0]  hdr_rdy;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int n;
    tbl[0] = '{req: 4'b0001, grant: 2'd0, busy: 1'b1, hdr_rdy: 4'b0001};
    tbl[1] = '{req: 4'b0110, grant: 2'd1, busy: 1'b1, hdr_rdy: 4'b0010};
    tbl[2] = '{req: 4'b1000, grant: 2'd3, busy: 1'b1, hdr_rdy: 4'b1000};
    tbl[3] = '{req: 4'b1100, grant: 2'd2, busy: 1'b1, hdr_rdy: 4'b0100};
    tbl[4] = '{req: 4'b1010, grant: 2'd1, busy: 1'b1, hdr_rdy: 4'b0010};
    tbl[5] = '{req: 4'b0000, grant: 2'd0, busy: 1'b0, hdr_rdy: 4'b0000};

    // Arbitration from reset, then withdrawal of the header returns to idle.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      check("rst_outputs", {grant_index, busy, m_udp_hdr_valid, m_tvalid, s_udp_hdr_ready, s_tready},
            128'd0);
      check("rst_hdr", m_udp_hdr, 128'd0);
      s_udp_hdr_valid = tbl[i].req;
      @(posedge clk); #1;
      check("tbl_grant", {grant_index, busy, s_udp_hdr_ready},
            {tbl[i].grant, tbl[i].busy, tbl[i].hdr_rdy});
      s_udp_hdr_valid = '0;
      @(posedge clk); #1;
      check("tbl_withdraw", {busy, s_udp_hdr_ready}, 128'd0);
    end

    // Single frame from port 1.
    do_reset();
    add_frame(1, 128'h0A000001_0A000002_C350_CA6C_0018_0000, 2, 64'h1111_0000_0000_0000, 8'h0F, 1'b0);
    run_batch(100);
    check("p1_grant", grant_index, 128'd1);
    check("p1_len", m_udp_hdr[LEN_LSB +: 16], 128'h0018);
    check("p1_dport", m_udp_hdr[DST_PORT_LSB +: 16], 128'hCA6C);
    check("p1_beats", 128'(beats_seen), 128'd2);

    // All four ports at once, then ports 0 and 2.
    do_reset();
    for (int p = 0; p < S; p++) add_frame(p, {4{28'h0, 4'(p)}}, 2, 64'(p) << 32, 8'hFF, 1'b0);
    run_batch(200);
    check("rr4_count", 128'(obs_q.size()), 128'd4);
    for (int k = 0; k < 4; k++) check("rr4_order", 128'(obs_q.size() > k ? obs_q[k] : -1), 128'(k));
    add_frame(2, 128'hAA, 1, 64'hA0, 8'h01, 1'b0);
    add_frame(0, 128'hBB, 1, 64'hB0, 8'h03, 1'b0);
    run_batch(100);
    check("rr2_first", 128'(obs_q.size() > 0 ? obs_q[0] : -1), 128'd0);
    check("rr2_second", 128'(obs_q.size() > 1 ? obs_q[1] : -1), 128'd2);

    // Toggling downstream tready on a 5-beat frame.
    do_reset();
    tready_mode = 1;
    add_frame(2, 128'hC0FFEE, 5, 64'hDEAD_BEEF_0000_0000, 8'h7F, 1'b1);
    run_batch(100);
    check("toggle_beats", 128'(beats_seen), 128'd5);

    // Header held off for 10 cycles while the payload streams.
    do_reset();
    hdr_hold = cyc + 10;
    add_frame(0, 128'h1234_5678, 6, 64'h5555_0000, 8'hFF, 1'b0);
    run_batch(100);
    check("hdr_hold_pay", 128'(pay_while_hdr), 128'd6);

    // Reset in the middle of a frame; pointer must restart at 0.
    do_reset();
    add_frame(2, 128'h22, 1, 64'h22, 8'hFF, 1'b0);
    run_batch(100);
    add_frame(0, 128'h33, 4, 64'h3300, 8'hFF, 1'b0);
    exp_hdr_q.push_back(src_q[0][0]);
    exp_pay_q.push_back(src_q[0][0]);
    n = 0;
    while (exp_beat < 2 && n < 50) begin
      tick();
      n++;
    end
    check("midframe_reached", 128'(exp_beat), 128'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_m", {m_tvalid, m_tdata, m_tkeep, m_tlast, m_udp_hdr_valid}, 128'd0);
    check("async_rst_state", {grant_index, busy, s_udp_hdr_ready, s_tready}, 128'd0);
    check("async_rst_hdr", m_udp_hdr, 128'd0);
    flush();
    drive();
    @(posedge clk); #1;
    rst = 1'b0;
    add_frame(3, 128'h4444, 2, 64'h4400, 8'hFF, 1'b0);
    add_frame(1, 128'h1111, 2, 64'h1100, 8'hFF, 1'b0);
    run_batch(100);
    check("post_rst_first", 128'(obs_q.size() > 0 ? obs_q[0] : -1), 128'd1);
    check("post_rst_second", 128'(obs_q.size() > 1 ? obs_q[1] : -1), 128'd3);

    // Randomized traffic with backpressure on every interface.
    for (int b = 0; b < 12; b++) begin
      tready_mode = 2; hdr_mode = 2; src_rand = 1;
      for (int p = 0; p < S; p++) begin
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++)
          add_frame(p, {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, 6),
                    {$urandom, $urandom}, 8'($urandom_range(1, 255)), 1'($urandom_range(0, 1)));
      end
      run_batch(3000);
    end

`ifdef UDP_TX_ARB_STATS_EN
    // Per-port counters: three frames on port 2, the last one errored.
    do_reset();
    add_frame(2, 128'h2001, 2, 64'h10, 8'hFF, 1'b0);
    add_frame(2, 128'h2002, 1, 64'h20, 8'hFF, 1'b0);
    add_frame(2, 128'h2003, 3, 64'h30, 8'h01, 1'b1);
    run_batch(200);
    for (int p = 0; p < S; p++) begin
      check("frame_count", frame_count[p*16 +: 16], (p == 2) ? 128'd3 : 128'd0);
      check("err_count", err_count[p*16 +: 16], (p == 2) ? 128'd1 : 128'd0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule
